// File: rtl/sipo8_loader.sv
// rtl/sipo8_loader.sv - framed serial-to-parallel byte receiver feeding an 8-bit enabled register
//
// Receives start bit (0), 8 data bits, optional parity bit and stop bit (1)
// on a bit-strobe interface. Each accepted byte is presented on data_out
// with a one-cycle load_en pulse, which drive the downstream register's
// Reg_In and EN inputs.
//
// Parameters:
//   LSB_FIRST  1: first data bit after start is bit 0; 0: first is bit 7
//   PAR_ODD    parity sense when parity checking is compiled in
//              (0 = even, 1 = odd)
//
// Build option:
//   SIPO8_PARITY_CHECK_EN  when defined, a parity bit follows the 8 data
//                          bits; a parity mismatch rejects the frame the
//                          same way a bad stop bit does.
//
// Ports:
//   clk        rising-edge clock
//   res        asynchronous active-high reset
//   ser_en     bit strobe; ser_in is sampled only on edges with ser_en=1
//   ser_in     serial line, idles at 1
//   data_out   last correctly received byte
//   load_en    one-cycle pulse when data_out updates
//   frame_err  level; last frame had a bad stop bit (or parity)
//   busy       high while a frame is in progress

module sipo8_loader #(
    parameter bit LSB_FIRST = 1'b1,
    parameter bit PAR_ODD   = 1'b0
) (
    input  logic       clk,
    input  logic       res,
    input  logic       ser_en,
    input  logic       ser_in,
    output logic [7:0] data_out,
    output logic       load_en,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t     state;
    logic [2:0] bit_cnt;
    logic [7:0] shift_reg;
    logic [7:0] shift_next;
    logic       par_err;

    // Bit order only changes which end of the shift register the new bit
    // enters; after 8 shifts the byte is aligned either way.
    assign shift_next = LSB_FIRST ? {ser_in, shift_reg[7:1]}
                                  : {shift_reg[6:0], ser_in};

`ifdef SIPO8_PARITY_CHECK_EN
    // Parity mismatch is captured in the PARITY state and only acted on at
    // STOP, so a frame is rejected in exactly one place.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            par_err <= 1'b0;
        end else if (ser_en) begin
            if (state == IDLE && !ser_in) begin
                par_err <= 1'b0;
            end else if (state == PARITY) begin
                par_err <= ((^shift_reg) ^ ser_in) != PAR_ODD;
            end
        end
    end
`else
    // Without the parity stage the parity sense has no effect.
    assign par_err = PAR_ODD & 1'b0;
`endif

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            shift_reg <= 8'h00;
            data_out  <= 8'h00;
            load_en   <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            // load_en is a pulse: it drops on the cycle after it was set,
            // regardless of ser_en.
            load_en <= 1'b0;
            if (ser_en) begin
                case (state)
                    IDLE: begin
                        // Any 0 in IDLE commits to a frame; no mid-bit
                        // revalidation of the start bit.
                        if (!ser_in) begin
                            state     <= DATA;
                            bit_cnt   <= 3'd0;
                            frame_err <= 1'b0;
                            busy      <= 1'b1;
                        end
                    end
                    DATA: begin
                        shift_reg <= shift_next;
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
`ifdef SIPO8_PARITY_CHECK_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
`ifdef SIPO8_PARITY_CHECK_EN
                    PARITY: begin
                        state <= STOP;
                    end
`endif
                    STOP: begin
                        if (ser_in && !par_err) begin
                            data_out  <= shift_reg;
                            load_en   <= 1'b1;
                            frame_err <= 1'b0;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/sipo8_loader.md
Name: sipo8_loader

Overview:
- Serial-to-parallel framed byte receiver; the stage directly upstream of the 8-bit enabled register.
- Collects start bit + 8 data bits + stop bit on a bit-strobe interface.
- On a valid frame, presents the byte on data_out with a one-cycle load_en pulse. These drive the register's Reg_In / EN inputs.

Parameters:
- LSB_FIRST, 1, 1 = first data bit after start is bit 0; 0 = first data bit is bit 7.
- PAR_ODD, 0, parity sense when parity is compiled in: 0 = even, 1 = odd.

Ports:
- clk  input  1  rising-edge clock.
- res  input  1  asynchronous active-high reset.
- ser_en  input  1  bit strobe; ser_in is sampled only on clk edges with ser_en=1.
- ser_in  input  1  serial line; idles at 1.
- data_out  output  8  last correctly received byte; feeds register Reg_In.
- load_en  output  1  one-cycle pulse when data_out updates; feeds register EN.
- frame_err  output  1  level; bad stop bit (or parity) on the last frame.
- busy  output  1  1 while a frame is in progress (state != IDLE).

Behaviour:
- Reset values: data_out=8'h00, load_en=0, frame_err=0, busy=0, state=IDLE, bit count=0, shift reg=0. Reset is asynchronous and overrides everything, including mid-frame.
- All outputs are registered. Nothing changes on cycles with ser_en=0, except load_en clearing.
- IDLE:
  - ser_en & ser_in=0 (start bit) -> DATA; clear bit count; clear frame_err.
  - ser_en & ser_in=1 -> stay in IDLE.
- DATA:
  - Each ser_en shifts ser_in into the shift reg.
  - LSB_FIRST=1: shift right, new bit enters bit 7. LSB_FIRST=0: shift left, new bit enters bit 0.
  - Bit count increments 0..7. The ser_en carrying the 8th bit (count=7) -> PARITY if compiled in, else STOP.
- STOP, on ser_en:
  - ser_in=1: data_out <= shift reg and load_en=1 for exactly one cycle (the cycle after the sampling edge). frame_err=0.
  - ser_in=0: frame_err=1; data_out unchanged; no load_en pulse.
  - Either case -> IDLE.
- Latency: data_out and load_en are valid one clk after the stop-bit sampling edge.
- Back-to-back frames: a start bit may be sampled on the ser_en immediately following the stop bit. load_en from the previous frame still pulses normally.
- Consecutive-cycle ser_en (ser_en held 1) is legal; every cycle is one bit.
- A glitch start (0 in IDLE) is committed. There is no start-bit revalidation.
- busy rises the cycle after the start bit is sampled and falls the cycle after the stop bit is sampled.
- load_en is never asserted for two consecutive cycles.

Optional Feature:
- Macro: SIPO8_PARITY_CHECK_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP, consuming one ser_en bit.
  - Expected parity: even (PAR_ODD=0) means XOR of the 8 data bits and the parity bit = 0; odd means = 1.
  - Mismatch is latched internally. At STOP, the frame is rejected exactly like a bad stop bit: frame_err=1, no load_en, data_out unchanged.
- Undefined: no PARITY state, 10-bit frame, PAR_ODD ignored.

Test Plan:
- Reset, then idle line (ser_in=1, ser_en toggling) -> data_out=8'h00, load_en=0, frame_err=0, busy=0 throughout.
- LSB_FIRST=1, frame for 0x77: start 0, bits 1,1,1,0,1,1,1,0, stop 1 -> data_out=8'h77, single load_en pulse one cycle after stop, busy low afterwards.
- Frame 0xA5 with stop bit 0 -> frame_err=1, no load_en, data_out keeps its previous value (8'h77). Next good frame 0x3C clears frame_err at its start bit and ends with data_out=8'h3C.
- Back-to-back frames 0xA5 then 0x3C with ser_en held high and ser_en gaps of 3 cycles between bits -> two load_en pulses; data_out shows 8'hA5, then 8'h3C.
- res asserted asynchronously after the 4th data bit of a frame -> immediate return to reset values. A following clean frame 0x81 is received correctly as 8'h81 (no residual bits).
- SIPO8_PARITY_CHECK_EN defined, PAR_ODD=0, frame 0x07 with parity bit 1 -> accepted, data_out=8'h07. Same frame with parity bit 0 -> frame_err=1, no load_en.
